mpwm_axil_slave: RTL and testbench
==================================

Name: mpwm_axil_slave

Overview:
AXI4-Lite slave register file for the MPWM IP: the responder that the S00_AXI master VIP drives.
- Holds NUM_REGS 32-bit read/write configuration words.
- Returns OKAY/SLVERR responses.
- Presents a shadow copy of the words to the PWM core; the shadow loads only on the core's period-boundary pulse, so mid-period writes never glitch the outputs.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width.
- NUM_REGS, 4: number of RW words, at byte offsets 0x00, 0x04, ...; requires NUM_REGS*4 <= 2**C_S_AXI_ADDR_WIDTH.

Ports:
- s00_axi_aclk  in  1  single clock.
- s00_axi_areset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1 each  write address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1 each  write data handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1 each  write response handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1 each  read address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1 each  read data handshake.
- upd_i  in  1  period-boundary pulse from the PWM core; loads the shadow.
- cfg_o  out  NUM_REGS*32  shadow words; word k is at bits [32k+31:32k].
- wr_stb_o  out  NUM_REGS  one-cycle pulse when word k is written.

Behaviour:
- Interface: one clock, s00_axi_aclk. Reset s00_axi_areset is synchronous and active-high.
- Reset values:
  - all register words 0, cfg_o 0, wr_stb_o 0;
  - bvalid 0, rvalid 0, bresp 0, rresp 0, rdata 0;
  - AW/W holding flags cleared;
  - awready, wready, arready forced 0 while reset is high.
- Reset mid-transaction: any pending AW, W, B or R is discarded; bvalid and rvalid are 0 on the cycle after reset is sampled.
- Address decode:
  - index = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
  - index >= NUM_REGS is out of range.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid (combinational from registered state).
  - AW and W may be accepted in either order or in the same cycle; each is latched into a holding register.
  - Commit edge: the first edge at which both are held, counting a handshake on that same edge.
  - At the commit edge:
    - in range: byte j of the word updated iff wstrb[j]; wr_stb_o[index] pulses high for 1 cycle; bresp=OKAY (00);
    - out of range: no register change; bresp=SLVERR (10);
    - bvalid rises; both holding flags clear.
  - Latency: AW and W in the same cycle at cycle N gives the register value and bvalid at N+1.
  - bvalid holds, with bresp stable, until the bvalid&&bready edge.
  - No new AW/W is accepted while bvalid is high.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake at cycle N, rdata/rresp/rvalid are registered and valid at N+1.
  - In range: word value, rresp=OKAY. Out of range: rdata=0, rresp=SLVERR.
  - rvalid, rdata and rresp hold until the rvalid&&rready edge; no new AR is accepted meanwhile.
- Readback returns the programmed word, not the shadow.
- Read/write collision: if the AR handshake and a write commit to the same index fall on the same edge, the read returns the pre-write value.
- Shadow:
  - when upd_i is high, all cfg_o words load the programmed words on that edge.
  - If upd_i coincides with a write commit, the shadow loads the pre-write value; the new value appears at the next upd_i.
- Read and write channels are fully independent; one of each may be outstanding.

Decomposition:
- Package mpwm_axil_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - a word-index typedef;
  - a byte-merge function (old, new, strobe) -> merged word.
- One natural sub-module: mpwm_axil_wr_ctrl, covering AW/W hold flags, commit generation and B handshake.
- Read path, register array and shadow remain in the top.

Test Plan:
- Back-to-back writes 0x1,0x2,0x3,0x4 to 0x00..0x0C, then reads 0x00..0x0C -> rdata 0x1..0x4 in order, all bresp/rresp OKAY, wr_stb_o bits 0..3 pulse once each.
- After those writes, upd_i low -> cfg_o stays 0; pulse upd_i once -> cfg_o = {0x4,0x3,0x2,0x1} on the next cycle.
- Word 0x00 = 0xAABBCCDD, then write 0x11223344 with wstrb=0101 -> readback 0xAA22CC44.
- Write to 0x10 and read 0x14 -> bresp=SLVERR, rresp=SLVERR, rdata=0, no register change, no wr_stb_o pulse.
- W at cycle 2, AW at cycle 6, bready low for 5 cycles -> wready low after cycle 2, commit at the cycle-6 edge, bvalid held stable through the stall, awready/wready stay 0 until B completes.
- Reset asserted while rvalid is high and bready low -> rvalid/bvalid are 0 the next cycle, all words read 0 after reset.

Source files
------------

// File: rtl/mpwm_axil_pkg.sv
// Shared types, response codes and the byte-lane merge helper for the MPWM AXI4-Lite slave.
package mpwm_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Wide enough for any word index a 32-bit byte address can carry.
    typedef logic [29:0] word_idx_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_w;
        for (int unsigned j = 0; j < 4; j++) begin
            if (strb[j]) merged[8*j +: 8] = new_w[8*j +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mpwm_axil_wr_ctrl.sv
// AXI4-Lite write side: AW/W holding registers, commit generation and the B handshake.
module mpwm_axil_wr_ctrl
    import mpwm_axil_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,
    output logic                commit_o,
    output logic                commit_ok_o,
    output word_idx_t           commit_idx_o,
    output logic [DATA_W-1:0]   commit_data_o,
    output logic [DATA_W/8-1:0] commit_strb_o
);

    logic                aw_held_q, aw_held_d;
    logic                w_held_q,  w_held_d;
    word_idx_t           awidx_q,   awidx_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W/8-1:0] wstrb_q,   wstrb_d;
    logic                bvalid_q,  bvalid_d;
    logic [1:0]          bresp_q,   bresp_d;

    logic      aw_hs, w_hs;
    word_idx_t awidx_in;
    logic      unused_addr_lsbs;

    assign unused_addr_lsbs = ^awaddr_i[1:0];
    assign awidx_in = word_idx_t'(awaddr_i[ADDR_W-1:2]);

    assign awready_o = !aw_held_q && !bvalid_q && !rst_i;
    assign wready_o  = !w_held_q  && !bvalid_q && !rst_i;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i  && wready_o;

    // A handshake on the same edge counts as held, so the commit never waits an extra cycle.
    assign commit_o      = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign commit_idx_o  = aw_held_q ? awidx_q : awidx_in;
    assign commit_data_o = w_held_q  ? wdata_q : wdata_i;
    assign commit_strb_o = w_held_q  ? wstrb_q : wstrb_i;
    assign commit_ok_o   = commit_idx_o < word_idx_t'(NUM_REGS);

    assign bvalid_o = bvalid_q;
    assign bresp_o  = bresp_q;

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = commit_ok_o ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awidx_d   = awidx_in;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = wdata_i;
                wstrb_d  = wstrb_i;
            end
            if (bvalid_q && bready_i) bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: rtl/mpwm_axil_slave.sv
// MPWM AXI4-Lite register file: programmed words, read path and the period-aligned shadow copy.
module mpwm_axil_slave
    import mpwm_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 s00_axi_aclk,
    input  logic                                 s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
    input  logic [2:0]                           s00_axi_awprot,
    input  logic                                 s00_axi_awvalid,
    output logic                                 s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
    input  logic                                 s00_axi_wvalid,
    output logic                                 s00_axi_wready,
    output logic [1:0]                           s00_axi_bresp,
    output logic                                 s00_axi_bvalid,
    input  logic                                 s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
    input  logic [2:0]                           s00_axi_arprot,
    input  logic                                 s00_axi_arvalid,
    output logic                                 s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
    output logic [1:0]                           s00_axi_rresp,
    output logic                                 s00_axi_rvalid,
    input  logic                                 s00_axi_rready,
    input  logic                                 upd_i,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_o,
    output logic [NUM_REGS-1:0]                  wr_stb_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic [DW-1:0]          regs_q [NUM_REGS];
    logic [NUM_REGS*DW-1:0] shadow_q;
    logic [NUM_REGS-1:0]    wr_stb_q, wr_stb_d;
    logic                   rvalid_q, rvalid_d;
    logic [DW-1:0]          rdata_q,  rdata_d;
    logic [1:0]             rresp_q,  rresp_d;

    logic            commit, commit_ok;
    word_idx_t       commit_idx;
    logic [DW-1:0]   commit_data;
    logic [DW/8-1:0] commit_strb;

    logic            ar_hs, rd_ok;
    word_idx_t       ridx;
    logic [DW-1:0]   rd_word;
    logic            unused_inputs;

    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[1:0]};

    mpwm_axil_wr_ctrl #(
        .ADDR_W  (C_S_AXI_ADDR_WIDTH),
        .DATA_W  (C_S_AXI_DATA_WIDTH),
        .NUM_REGS(NUM_REGS)
    ) u_wr_ctrl (
        .clk_i        (s00_axi_aclk),
        .rst_i        (s00_axi_areset),
        .awaddr_i     (s00_axi_awaddr),
        .awvalid_i    (s00_axi_awvalid),
        .awready_o    (s00_axi_awready),
        .wdata_i      (s00_axi_wdata),
        .wstrb_i      (s00_axi_wstrb),
        .wvalid_i     (s00_axi_wvalid),
        .wready_o     (s00_axi_wready),
        .bresp_o      (s00_axi_bresp),
        .bvalid_o     (s00_axi_bvalid),
        .bready_i     (s00_axi_bready),
        .commit_o     (commit),
        .commit_ok_o  (commit_ok),
        .commit_idx_o (commit_idx),
        .commit_data_o(commit_data),
        .commit_strb_o(commit_strb)
    );

    assign s00_axi_arready = !rvalid_q && !s00_axi_areset;
    assign ar_hs           = s00_axi_arvalid && s00_axi_arready;
    assign ridx            = word_idx_t'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);
    assign rd_ok           = ridx < word_idx_t'(NUM_REGS);

    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (ridx == word_idx_t'(k)) rd_word = regs_q[k];
        end
    end

    always_comb begin
        wr_stb_d = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            wr_stb_d[k] = commit && commit_ok && (commit_idx == word_idx_t'(k));
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_ok ? rd_word : '0;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Reads and shadow loads sample regs_q before this edge's write lands: pre-write on collision.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            shadow_q <= '0;
            wr_stb_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_stb_d[k]) regs_q[k] <= byte_merge(regs_q[k], commit_data, commit_strb);
                if (upd_i) shadow_q[k*DW +: DW] <= regs_q[k];
            end
            wr_stb_q <= wr_stb_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign cfg_o          = shadow_q;
    assign wr_stb_o       = wr_stb_q;
    assign s00_axi_rvalid = rvalid_q;
    assign s00_axi_rdata  = rdata_q;
    assign s00_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_mpwm_axil_slave.sv
// Directed self-checking bench for mpwm_axil_slave with hand-computed expectations.
module tb_mpwm_axil_slave;

    localparam int AW = 5;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              areset;
    logic [AW-1:0]     awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic              upd;
    logic [NR*32-1:0]  cfg;
    logic [NR-1:0]     wr_stb;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          stb_cnt [NR] = '{default: 0};

    always #5 clk = ~clk;

    mpwm_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS          (NR)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (areset),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .upd_i          (upd),
        .cfg_o          (cfg),
        .wr_stb_o       (wr_stb)
    );

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (wr_stb[i] === 1'b1) stb_cnt[i]++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [3:0] stb, output int unsigned lat);
        bit aw_go, w_go;
        int unsigned n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            n++;
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("wr_bvalid_seen", bvalid, 1);
        resp = bresp;
        stb  = wr_stb;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int unsigned lat);
        bit go;
        int unsigned n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            go = arready;
            tick();
            n++;
            if (go) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("rd_rvalid_seen", rvalid, 1);
        d    = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  stb;
        logic [31:0] d;
        int unsigned lat;
        logic [31:0] exp_words [NR];

        areset = 1'b1; awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b001;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0; upd = 1'b0;
        repeat (3) tick();
        check_eq("rst_awready", awready, 0);
        check_eq("rst_wready", wready, 0);
        check_eq("rst_arready", arready, 0);
        check_eq("rst_bvalid", bvalid, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_bresp", bresp, 0);
        check_eq("rst_rresp", rresp, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_cfg", cfg, 0);
        check_eq("rst_wr_stb", wr_stb, 0);
        areset = 1'b0;
        tick();
        check_eq("idle_awready", awready, 1);
        check_eq("idle_arready", arready, 1);

        // Back-to-back writes then readback
        for (int i = 0; i < NR; i++) begin
            axi_write(AW'(i * 4), 32'(i + 1), 4'hF, resp, stb, lat);
            check_eq($sformatf("wr%0d_bresp", i), resp, 2'b00);
            check_eq($sformatf("wr%0d_stb", i), stb, 4'b0001 << i);
            check_eq($sformatf("wr%0d_lat", i), lat, 0);
        end
        check_eq("wr_stb_cleared", wr_stb, 0);
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(i * 4), d, resp, lat);
            check_eq($sformatf("rd%0d_data", i), d, 32'(i + 1));
            check_eq($sformatf("rd%0d_rresp", i), resp, 2'b00);
            check_eq($sformatf("rd%0d_lat", i), lat, 0);
        end
        for (int i = 0; i < NR; i++) check_eq($sformatf("stb_cnt%0d", i), stb_cnt[i], 1);

        // Shadow only follows upd_i
        check_eq("cfg_no_upd", cfg, 0);
        upd = 1'b1; tick(); upd = 1'b0;
        check_eq("cfg_upd", cfg, {32'h4, 32'h3, 32'h2, 32'h1});

        // Byte strobes
        axi_write(5'h00, 32'hAABBCCDD, 4'hF, resp, stb, lat);
        axi_write(5'h00, 32'h11223344, 4'b0101, resp, stb, lat);
        check_eq("strb_bresp", resp, 2'b00);
        axi_read(5'h00, d, resp, lat);
        check_eq("strb_readback", d, 32'hAA22CC44);
        check_eq("cfg_held_midperiod", cfg, {32'h4, 32'h3, 32'h2, 32'h1});

        // Out-of-range accesses; addr[1:0] ignored for in-range reads
        axi_write(5'h10, 32'hDEADBEEF, 4'hF, resp, stb, lat);
        check_eq("oor_bresp", resp, 2'b10);
        check_eq("oor_stb", stb, 0);
        axi_read(5'h14, d, resp, lat);
        check_eq("oor_rresp", resp, 2'b10);
        check_eq("oor_rdata", d, 0);
        exp_words = '{32'hAA22CC44, 32'h2, 32'h3, 32'h4};
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(i * 4 + 3), d, resp, lat);
            check_eq($sformatf("oor_nochange%0d", i), d, exp_words[i]);
        end

        // W first, AW four cycles later, B stalled five cycles
        bready = 1'b0; wdata = 32'h55; wstrb = 4'hF;
        check_eq("stag_wready_idle", wready, 1);
        wvalid = 1'b1; tick(); wvalid = 1'b0;
        check_eq("stag_wready_held", wready, 0);
        check_eq("stag_awready_open", awready, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("stag_wait_wready", wready, 0);
            check_eq("stag_wait_bvalid", bvalid, 0);
        end
        awaddr = 5'h04; awvalid = 1'b1; tick(); awvalid = 1'b0;
        check_eq("stag_bvalid", bvalid, 1);
        check_eq("stag_bresp", bresp, 2'b00);
        check_eq("stag_stb", wr_stb, 4'b0010);
        awaddr = 5'h08; wdata = 32'hDEAD; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("stall_bvalid", bvalid, 1);
            check_eq("stall_bresp", bresp, 2'b00);
            check_eq("stall_awready", awready, 0);
            check_eq("stall_wready", wready, 0);
        end
        bready = 1'b1; tick(); awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        check_eq("stag_bdone", bvalid, 0);
        check_eq("stag_awready_back", awready, 1);
        check_eq("stag_wready_back", wready, 1);
        axi_read(5'h04, d, resp, lat);
        check_eq("stag_readback", d, 32'h55);
        axi_read(5'h08, d, resp, lat);
        check_eq("stall_not_written", d, 32'h3);

        // Read, write commit and shadow load on the same edge, same index
        awaddr = 5'h08; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h08; arvalid = 1'b1; upd = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; upd = 1'b0;
        check_eq("coll_rvalid", rvalid, 1);
        check_eq("coll_rdata_prewrite", rdata, 32'h3);
        check_eq("coll_bvalid", bvalid, 1);
        check_eq("coll_cfg_prewrite", cfg, {32'h4, 32'h3, 32'h55, 32'hAA22CC44});
        bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
        check_eq("coll_bdone", bvalid, 0);
        check_eq("coll_rdone", rvalid, 0);
        upd = 1'b1; tick(); upd = 1'b0;
        check_eq("coll_cfg_next", cfg, {32'h4, 32'h99, 32'h55, 32'hAA22CC44});

        // Reset with R and B both pending
        araddr = 5'h00; arvalid = 1'b1; tick(); arvalid = 1'b0;
        check_eq("prerst_rvalid", rvalid, 1);
        awaddr = 5'h04; wdata = 32'h77; awvalid = 1'b1; wvalid = 1'b1; tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("prerst_bvalid", bvalid, 1);
        areset = 1'b1; tick();
        check_eq("midrst_rvalid", rvalid, 0);
        check_eq("midrst_bvalid", bvalid, 0);
        check_eq("midrst_awready_forced", awready, 0);
        check_eq("midrst_arready_forced", arready, 0);
        check_eq("midrst_cfg", cfg, 0);
        areset = 1'b0; tick();
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(i * 4), d, resp, lat);
            check_eq($sformatf("postrst_word%0d", i), d, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
